// File: rtl/mem_bridge_ctrl.sv
// MEM-stage bridge that maps out-of-data-memory accesses onto two devices.
// Stalls the pipeline across a req/ack handshake with a wait-state timeout.
module mem_bridge_ctrl #(
    parameter logic [15:0] DEV0_BASE = 16'h7F00,
    parameter logic [15:0] DEV1_BASE = 16'h7F10,
    parameter int          DEV_SPAN  = 16,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PrReq,
    input  logic        PrWe,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  PrBE,
    output logic [31:0] PrRD,
    output logic        PrStall,
    output logic        PrErr,
    output logic [1:0]  DEV_Sel,
    output logic        DEV_Req,
    output logic        DEV_We,
    output logic [29:0] DEV_Addr,
    output logic [31:0] DEV_WD,
    output logic [3:0]  DEV_BE,
    input  logic [1:0]  DEV_Ack,
    input  logic [31:0] DEV_RD0,
    input  logic [31:0] DEV_RD1
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [16:0] DEV0_END = {1'b0, DEV0_BASE} + 17'(DEV_SPAN);
    localparam logic [16:0] DEV1_END = {1'b0, DEV1_BASE} + 17'(DEV_SPAN);
    localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic [16:0] a17;
    logic        in_dm;
    logic        hit0;
    logic        hit1;
    logic        ack_hit;
    logic [31:0] rd_sel;

    // 17-bit compare keeps the range end from wrapping near 16'hFFFF
    assign a17     = {1'b0, PrAddr[15:0]};
    assign in_dm   = PrAddr[15:0] < 16'h3000;
    assign hit0    = (a17 >= {1'b0, DEV0_BASE}) && (a17 < DEV0_END);
    assign hit1    = (a17 >= {1'b0, DEV1_BASE}) && (a17 < DEV1_END);
    assign ack_hit = |(DEV_Ack & DEV_Sel);
    assign rd_sel  = DEV_Sel[1] ? DEV_RD1 : DEV_RD0;

    assign PrStall = ((state == IDLE) && PrReq && !in_dm) || (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PrRD     <= '0;
            PrErr    <= 1'b0;
            DEV_Sel  <= '0;
            DEV_Req  <= 1'b0;
            DEV_We   <= 1'b0;
            DEV_Addr <= '0;
            DEV_WD   <= '0;
            DEV_BE   <= '0;
        end else begin
            PrErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (PrReq && !in_dm) begin
                        if (hit0 || hit1) begin
                            DEV_Sel  <= {hit1 & ~hit0, hit0};
                            DEV_We   <= PrWe;
                            DEV_Addr <= PrAddr[31:2];
                            DEV_WD   <= PrWD;
                            DEV_BE   <= PrBE;
                            DEV_Req  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= BUSY;
                        end else begin
                            PrRD  <= ERR_WORD;
                            PrErr <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (ack_hit) begin
                        if (!DEV_We) begin
                            PrRD <= rd_sel;
                        end
                        DEV_Req <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        PrRD    <= ERR_WORD;
                        PrErr   <= 1'b1;
                        DEV_Req <= 1'b0;
                        state   <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
